// File: rtl/store_drain_queue_pkg.sv
// Shared types for the store drain path: word width, default queue depth
// and the layout of one queued committed store.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P = 16;
  localparam int WQ_ENTRY_P  = 4;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] address;
    logic [WORD_SIZE_P-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/store_drain_queue_if.sv
// Bundles the store-buffer, load and data-memory handshakes of the drain queue.
// slave is the queue's own view; master is the surrounding core/memory view.
interface store_drain_queue_if;
  import Purple_Jade_pkg::*;

  logic                   sb_mem_v_i;
  logic [WORD_SIZE_P-1:0] sb_mem_addr_i;
  logic [WORD_SIZE_P-1:0] sb_mem_data_i;
  logic                   wq_ready_o;
  logic                   rob_mispredict_i;
  logic                   exe_ld_v_i;
  logic [WORD_SIZE_P-1:0] exe_ld_addr_i;
  logic                   ld_ready_o;
  logic                   ld_resp_v_o;
  logic [WORD_SIZE_P-1:0] ld_resp_data_o;
  logic                   mem_v_o;
  logic                   mem_we_o;
  logic [WORD_SIZE_P-1:0] mem_addr_o;
  logic [WORD_SIZE_P-1:0] mem_wdata_o;
  logic                   mem_ready_i;
  logic [WORD_SIZE_P-1:0] mem_rdata_i;

  modport slave (
    input  sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i, rob_mispredict_i,
    input  exe_ld_v_i, exe_ld_addr_i, mem_ready_i, mem_rdata_i,
    output wq_ready_o, ld_ready_o, ld_resp_v_o, ld_resp_data_o,
    output mem_v_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i, rob_mispredict_i,
    output exe_ld_v_i, exe_ld_addr_i, mem_ready_i, mem_rdata_i,
    input  wq_ready_o, ld_ready_o, ld_resp_v_o, ld_resp_data_o,
    input  mem_v_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/store_drain_queue_fwd_match.sv
// Youngest-match search over a circular queue. The per-entry match vector is
// rotated so slot 0 is the head (oldest); the highest live slot that matches
// is the youngest store, and adding head back un-rotates it to a queue index.
module wq_fwd_match
  import Purple_Jade_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [$clog2(N)-1:0]   head,
  input  logic [$clog2(N):0]     count,
  input  logic [WORD_SIZE_P-1:0] entry_addr [N],
  input  logic [WORD_SIZE_P-1:0] ld_addr,
  output logic                   hit,
  output logic [$clog2(N)-1:0]   idx
);
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;

  logic [N-1:0]  rot_match;
  logic [PW-1:0] rot_idx;

  // Match vector in age order: slot k is the k-th oldest live entry
  always_comb begin
    for (int k = 0; k < N; k++) begin
      rot_match[k] = (CW'(k) < count) &&
                     (entry_addr[head + PW'(k)] == ld_addr);
    end
  end

  // Priority pick: a later (younger) slot overrides an earlier one
  always_comb begin
    hit     = 1'b0;
    rot_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (rot_match[k]) begin
        hit     = 1'b1;
        rot_idx = PW'(k);
      end
    end
  end

  assign idx = head + rot_idx;

endmodule

// File: rtl/store_drain_queue.sv
// Committed-store drain queue: buffers stores from the store buffer, drains
// them FIFO into a single-port data memory shared with execute-stage loads,
// and forwards load data straight from queued stores when addresses match.
module store_drain_queue
  import Purple_Jade_pkg::*;
#(
  parameter int WQ_ENTRY = WQ_ENTRY_P
) (
  input  logic clk_i,
  input  logic reset_n_i,
  store_drain_queue_if.slave bus
);
  localparam int PW = $clog2(WQ_ENTRY);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WQ_ENTRY);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  wq_entry_t              q_mem      [WQ_ENTRY];
  logic [WORD_SIZE_P-1:0] entry_addr [WQ_ENTRY];
  logic [PW-1:0]          head, tail, fwd_idx;
  logic [CW-1:0]          count;
  logic [0:0]             state;

  logic full, empty, push, pop;
  logic in_idle, ld_live, fwd_hit, fwd_acc, rd_sel, rd_acc, drain_sel;

  logic                   resp_vld_p1;
  logic [WORD_SIZE_P-1:0] resp_data_p1;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = bus.sb_mem_v_i & ~full;
  // Combinational outputs are gated by reset so they drop the moment it asserts
  assign in_idle = reset_n_i & (state == IDLE);
  // A mispredict kills the load in the cycle it is presented
  assign ld_live = bus.exe_ld_v_i & ~bus.rob_mispredict_i;

  // Forward hits never touch memory, so the port stays free for a drain.
  // A full queue always drains first so the store buffer cannot deadlock.
  assign fwd_acc   = in_idle & ld_live & fwd_hit;
  assign rd_sel    = in_idle & ld_live & ~fwd_hit & ~full;
  assign drain_sel = in_idle & ~empty & ~rd_sel;
  assign rd_acc    = rd_sel & bus.mem_ready_i;
  assign pop       = drain_sel & bus.mem_ready_i;

  // Address view of the queue for the forwarding search
  always_comb begin
    for (int i = 0; i < WQ_ENTRY; i++) begin
      entry_addr[i] = q_mem[i].address;
    end
  end

  wq_fwd_match #(
    .N (WQ_ENTRY)
  ) u_fwd_match (
    .head       (head),
    .count      (count),
    .entry_addr (entry_addr),
    .ld_addr    (bus.exe_ld_addr_i),
    .hit        (fwd_hit),
    .idx        (fwd_idx)
  );

  // Queue storage: data only, validity is carried by head/count
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_mem[tail] <= '{address: bus.sb_mem_addr_i, data: bus.sb_mem_data_i};
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at WQ_ENTRY
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load FSM: RD_WAIT is the single cycle in which read data returns
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (rd_acc) state <= RD_WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: load response register ----
  // Forwarded data or captured memory data, killed by a mispredict
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_vld_p1  <= 1'b0;
      resp_data_p1 <= '0;
    end else if (bus.rob_mispredict_i) begin
      resp_vld_p1  <= 1'b0;
    end else if (fwd_acc) begin
      resp_vld_p1  <= 1'b1;
      resp_data_p1 <= q_mem[fwd_idx].data;
    end else if (state == RD_WAIT) begin
      resp_vld_p1  <= 1'b1;
      resp_data_p1 <= bus.mem_rdata_i;
    end else begin
      resp_vld_p1  <= 1'b0;
    end
  end

  // Memory request mux: head entry for a drain, load address for a read
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (drain_sel) begin
      bus.mem_addr_o  = q_mem[head].address;
      bus.mem_wdata_o = q_mem[head].data;
    end else if (rd_sel) begin
      bus.mem_addr_o  = bus.exe_ld_addr_i;
    end
  end

  assign bus.wq_ready_o     = ~full;
  assign bus.ld_ready_o     = fwd_acc | rd_acc;
  assign bus.mem_v_o        = drain_sel | rd_sel;
  assign bus.mem_we_o       = drain_sel;
  assign bus.ld_resp_v_o    = resp_vld_p1;
  assign bus.ld_resp_data_o = resp_data_p1;

  // The ROB gates stores with wq_ready_o; a push into a full queue is dropped
  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(bus.sb_mem_v_i && full)
  );

endmodule

// File: tb/tb_store_drain_queue.sv
// Bench for store_drain_queue: scoreboarded memory writes and load responses
// checked against a reference memory model, plus directed timing scenarios.
module tb_store_drain_queue;
  import Purple_Jade_pkg::*;

  localparam int W = WORD_SIZE_P;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  logic clk_i = 1'b0;
  logic reset_n_i;

  always #5 clk_i = ~clk_i;

  store_drain_queue_if bus ();

  store_drain_queue #(
    .WQ_ENTRY (4)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int rd_cnt       = 0;
  int wr_cnt       = 0;

  wr_t          exp_wr   [$];
  logic [W-1:0] exp_resp [$];
  logic [W-1:0] mem_model [logic [W-1:0]];
  logic [W-1:0] arch      [logic [W-1:0]];

  function automatic logic [W-1:0] rd_mem(input logic [W-1:0] a);
    return mem_model.exists(a) ? mem_model[a] : '0;
  endfunction

  function automatic logic [W-1:0] rd_arch(input logic [W-1:0] a);
    return arch.exists(a) ? arch[a] : rd_mem(a);
  endfunction

  // Memory model and scoreboards, sampled on the falling edge
  always @(negedge clk_i) begin
    wr_t e;
    logic [W-1:0] r;
    if (reset_n_i === 1'b1) begin
      if (bus.mem_v_o && bus.mem_ready_i) begin
        if (bus.mem_we_o) begin
          wr_cnt++;
          tests_run++;
          if (exp_wr.size() == 0) begin
            tests_failed++;
            $display("FAIL mem_write unexpected addr=%h data=%h", bus.mem_addr_o, bus.mem_wdata_o);
          end else begin
            e = exp_wr.pop_front();
            if (bus.mem_addr_o !== e.a || bus.mem_wdata_o !== e.d) begin
              tests_failed++;
              $display("FAIL mem_write got %h<-%h want %h<-%h", bus.mem_addr_o, bus.mem_wdata_o, e.a, e.d);
            end
          end
          mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
        end else begin
          rd_cnt++;
          bus.mem_rdata_i = rd_mem(bus.mem_addr_o);
        end
      end
      if (bus.ld_resp_v_o) begin
        tests_run++;
        if (exp_resp.size() == 0) begin
          tests_failed++;
          $display("FAIL ld_resp unexpected data=%h", bus.ld_resp_data_o);
        end else begin
          r = exp_resp.pop_front();
          if (bus.ld_resp_data_o !== r) begin
            tests_failed++;
            $display("FAIL ld_resp data got %h want %h", bus.ld_resp_data_o, r);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_store(input logic [W-1:0] a, input logic [W-1:0] d);
    int t = 0;
    while (!bus.wq_ready_o && t < 50) begin
      step();
      t++;
    end
    tests_run++;
    if (bus.wq_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_ready wq_ready_o=%b want 1", bus.wq_ready_o);
    end else begin
      bus.sb_mem_v_i    = 1'b1;
      bus.sb_mem_addr_i = a;
      bus.sb_mem_data_i = d;
      arch[a] = d;
      exp_wr.push_back('{a: a, d: d});
    end
    step();
    bus.sb_mem_v_i = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] a, input bit kill);
    bit acc = 1'b0;
    int t = 0;
    bus.exe_ld_v_i    = 1'b1;
    bus.exe_ld_addr_i = a;
    while (!acc && t < 100) begin
      @(negedge clk_i);
      if (bus.ld_ready_o === 1'b1) begin
        acc = 1'b1;
        if (!kill) exp_resp.push_back(rd_arch(a));
      end
      step();
      t++;
    end
    bus.exe_ld_v_i = 1'b0;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("FAIL ld_accept addr=%h never accepted, want accepted", a);
    end
    if (kill) begin
      bus.rob_mispredict_i = 1'b1;
      step();
      bus.rob_mispredict_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_wr.size() != 0 || exp_resp.size() != 0) && t < 300) begin
      step();
      t++;
    end
    tests_run++;
    if (exp_wr.size() != 0 || exp_resp.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout pending writes=%0d resps=%0d want 0 0", exp_wr.size(), exp_resp.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run++;
    if ({bus.ld_ready_o, bus.ld_resp_v_o, bus.ld_resp_data_o, bus.mem_v_o, bus.mem_we_o,
         bus.mem_addr_o, bus.mem_wdata_o} !== '0 || bus.wq_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ldr=%b rv=%b rd=%h mv=%b we=%b ma=%h wd=%h wqr=%b want all 0, wq_ready 1",
               tag, bus.ld_ready_o, bus.ld_resp_v_o, bus.ld_resp_data_o, bus.mem_v_o,
               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.wq_ready_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i            = 1'b0;
    bus.sb_mem_v_i       = 1'b0;
    bus.sb_mem_addr_i    = '0;
    bus.sb_mem_data_i    = '0;
    bus.rob_mispredict_i = 1'b0;
    bus.exe_ld_v_i       = 1'b0;
    bus.exe_ld_addr_i    = '0;
    bus.mem_ready_i      = 1'b0;
    #22;
    check_reset_outputs("reset_initial");
    step();
    reset_n_i = 1'b1;
    step();
    // Reset while a drain request is outstanding
    push_store(16'h0070, 16'h0007);
    push_store(16'h0071, 16'h0008);
    tests_run++;
    if (bus.mem_v_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 16'h0070) begin
      tests_failed++;
      $display("FAIL reset_pre_drain mv=%b we=%b ma=%h want 1 1 0070", bus.mem_v_o, bus.mem_we_o, bus.mem_addr_o);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("reset_mid_drain");
    exp_wr.delete();
    foreach (arch[k]) arch[k] = rd_mem(k);
    step();
    reset_n_i = 1'b1;
    step();
    tests_run++;
    if (bus.mem_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_queue_empty mem_v_o=%b want 0", bus.mem_v_o);
    end
  endtask

  task automatic test_fill_drain();
    int w0 = wr_cnt;
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_store(16'h0010 + 16'(i), 16'h0001 + 16'(i));
    tests_run++;
    if (bus.wq_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready wq_ready_o=%b want 0", bus.wq_ready_o);
    end
    bus.mem_ready_i = 1'b1;
    wait_drain();
    tests_run++;
    if (wr_cnt - w0 != 4) begin
      tests_failed++;
      $display("FAIL fill_write_count got %0d want 4", wr_cnt - w0);
    end
  endtask

  task automatic test_forward();
    int r0;
    bus.mem_ready_i = 1'b0;
    push_store(16'h0020, 16'h00AA);
    push_store(16'h0020, 16'h00BB);
    r0 = rd_cnt;
    do_load(16'h0020, 1'b0);
    tests_run++;
    if (bus.ld_resp_v_o !== 1'b1 || bus.ld_resp_data_o !== 16'h00BB) begin
      tests_failed++;
      $display("FAIL fwd_resp v=%b data=%h want 1 00bb", bus.ld_resp_v_o, bus.ld_resp_data_o);
    end
    tests_run++;
    if (rd_cnt != r0) begin
      tests_failed++;
      $display("FAIL fwd_no_read reads=%0d want 0", rd_cnt - r0);
    end
    bus.mem_ready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_miss();
    mem_model[16'h0030] = 16'h0055;
    bus.mem_ready_i   = 1'b1;
    bus.exe_ld_v_i    = 1'b1;
    bus.exe_ld_addr_i = 16'h0030;
    @(negedge clk_i);
    tests_run++;
    if (bus.mem_v_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 16'h0030 || bus.ld_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_issue mv=%b we=%b ma=%h ldr=%b want 1 0 0030 1",
               bus.mem_v_o, bus.mem_we_o, bus.mem_addr_o, bus.ld_ready_o);
    end else begin
      exp_resp.push_back(rd_arch(16'h0030));
    end
    step();
    bus.exe_ld_v_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (bus.ld_resp_v_o !== 1'b0 || bus.mem_v_o !== 1'b0 || bus.ld_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_rd_wait rv=%b mv=%b ldr=%b want 0 0 0", bus.ld_resp_v_o, bus.mem_v_o, bus.ld_ready_o);
    end
    step();
    @(negedge clk_i);
    tests_run++;
    if (bus.ld_resp_v_o !== 1'b1 || bus.ld_resp_data_o !== 16'h0055) begin
      tests_failed++;
      $display("FAIL miss_resp v=%b data=%h want 1 0055", bus.ld_resp_v_o, bus.ld_resp_data_o);
    end
    step();
  endtask

  task automatic test_full_priority();
    mem_model[16'h0040] = 16'h0099;
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_store(16'h0050 + 16'(i), 16'h00A0 + 16'(i));
    bus.exe_ld_v_i    = 1'b1;
    bus.exe_ld_addr_i = 16'h0040;
    @(negedge clk_i);
    tests_run++;
    if (bus.mem_we_o !== 1'b1 || bus.ld_ready_o !== 1'b0 || bus.mem_addr_o !== 16'h0050) begin
      tests_failed++;
      $display("FAIL full_drain_wins we=%b ldr=%b ma=%h want 1 0 0050", bus.mem_we_o, bus.ld_ready_o, bus.mem_addr_o);
    end
    step();
    bus.mem_ready_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_v_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_drain_first mv=%b we=%b want 1 1", bus.mem_v_o, bus.mem_we_o);
    end
    step();
    @(negedge clk_i);
    tests_run++;
    if (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 16'h0040 || bus.ld_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_after_pop we=%b ma=%h ldr=%b want 0 0040 1", bus.mem_we_o, bus.mem_addr_o, bus.ld_ready_o);
    end else begin
      exp_resp.push_back(rd_arch(16'h0040));
    end
    step();
    bus.exe_ld_v_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_mispredict();
    mem_model[16'h0038] = 16'h0077;
    bus.mem_ready_i = 1'b1;
    push_store(16'h0060, 16'h00C0);
    push_store(16'h0061, 16'h00C1);
    push_store(16'h0062, 16'h00C2);
    do_load(16'h0038, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tests_run++;
      if (bus.ld_resp_v_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL mispredict_kill cycle %0d ld_resp_v_o=%b want 0", i, bus.ld_resp_v_o);
      end
      step();
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 16'h0080 + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        bus.mem_ready_i = bus.wq_ready_o ? 1'($urandom_range(0, 1)) : 1'b1;
        push_store(a, 16'($urandom));
      end else begin
        bus.mem_ready_i = 1'b1;
        do_load(a, 1'b0);
      end
    end
    bus.mem_ready_i = 1'b1;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_forward();
    test_miss();
    test_full_priority();
    test_mispredict();
    test_back_to_back();
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
